div_unit: RTL and testbench

- Multicycle signed 32-bit integer divider for the DIV instruction.
- Sits directly upstream of the HI/LO source multiplexers. Its registered quotient (lo_out) and remainder (hi_out) are data inputs that the mux selects into the HI/LO registers.
- Started by the control unit with a single-cycle pulse. Reports completion with a done pulse and reports divide-by-zero with an exception pulse.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_unit.sv | 111 +++++++++++
 tb/tb_div_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the DIV datapath: FSM encoding and width defaults.
package div_unit_pkg;

  localparam int DIV_DATA_WIDTH = 32;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to lo_out, remainder to hi_out.
// Operates on magnitudes, then fixes the signs in a single final cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  div_start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_busy,
  output logic                  div_done,
  output logic                  div_zero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  div_state_e            state, state_next;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] quo;      // holds |dividend|, shifts quotient bits in
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dvs;
  logic                  sign_q, sign_r;

  logic                  start_ok, zero_req;
  logic [DATA_WIDTH:0]   rem_shift, rem_diff;
  logic                  rem_ge;

  // The partial remainder stays below |divisor| <= 2^(W-1), so the shifted value
  // fits in W bits and the extra top bit of the difference is a clean borrow.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_next = state;
    start_ok   = 1'b0;
    zero_req   = 1'b0;
    rem_shift  = {rem, quo[DATA_WIDTH-1]};
    rem_diff   = rem_shift - {1'b0, dvs};
    rem_ge     = ~rem_diff[DATA_WIDTH];
    case (state)
      IDLE: begin
        if (div_start) begin
          if (divisor != '0) begin
            start_ok   = 1'b1;
            state_next = RUN;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      RUN:     if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_done <= 1'b0;
      div_zero <= zero_req;
      case (state)
        IDLE: begin
          if (start_ok) begin
            quo      <= dividend[DATA_WIDTH-1] ? -dividend : dividend;
            dvs      <= divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
            sign_q   <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            sign_r   <= dividend[DATA_WIDTH-1];
            rem      <= '0;
            cnt      <= CW'(DATA_WIDTH);
            div_busy <= 1'b1;
          end
        end
        RUN: begin
          rem <= rem_ge ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
          quo <= {quo[DATA_WIDTH-2:0], rem_ge};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          lo_out   <= sign_q ? -quo : quo;
          hi_out   <= sign_r ? -rem : rem;
          div_done <= 1'b1;
          div_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands,
// with a queue scoreboard fed at issue time and drained by an output monitor.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] hi_out, lo_out;
  logic         div_busy, div_done, div_zero;

  typedef struct {
    bit         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] last_hi  = '0;
  logic [W-1:0] last_lo  = '0;

  div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain signed arithmetic, truncating division, remainder follows dividend.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_, q, r;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.zero = (b == '0);
    e.hi   = '0;
    e.lo   = '0;
    if (!e.zero) begin
      q    = sa / sb_;
      r    = sa - q * sb_;
      e.lo = q[W-1:0];
      e.hi = r[W-1:0];
    end
    return e;
  endfunction

  // Monitor: every done/zero pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && (div_done || div_zero)) begin
      if (sb.size() == 0) begin
        check("sb_has_entry", W'(sb.size()), W'(1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", W'({div_zero, div_done}), e.zero ? W'(2) : W'(1));
        if (div_done) begin
          check("lo_out", lo_out, e.lo);
          check("hi_out", hi_out, e.hi);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(negedge clk);
    div_start = 1'b0;
  endtask

  // Called at the negedge after the start edge; returns edges until a pulse.
  task automatic wait_result(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!(div_done || div_zero) && lat < 100) begin
      if (div_busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("result_timeout", W'(lat), W'(33));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    bit busy_ok;
    exp_t e;
    e = model(a, b);
    issue(a, b, 1'b1);
    wait_result(lat, busy_ok);
    if (e.zero) begin
      check("zero_latency", W'(lat), W'(0));
      check("zero_busy", W'(div_busy), W'(0));
      check("zero_hold_hi", hi_out, last_hi);
      check("zero_hold_lo", lo_out, last_lo);
    end else begin
      check("latency", W'(lat), W'(33));
      check("busy_during_run", W'(busy_ok), W'(1));
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(negedge clk);
    check("pulse_cleared", W'({div_done, div_zero}), W'(0));
  endtask

  initial begin
    int   lat;
    bit   busy_ok;
    logic [W-1:0] ra, rb;

    reset     = 1'b1;
    div_start = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi_out, '0);
    check("reset_lo", lo_out, '0);
    check("reset_flags", W'({div_busy, div_done, div_zero}), W'(0));
    reset = 1'b0;

    run_op(32'd7, 32'd2);
    run_op(32'd5, 32'd0);                 // must hold 1 / 3
    run_op(32'hFFFF_FFF9, 32'd2);         // -7 / 2
    run_op(32'd7, 32'hFFFF_FFFE);         // 7 / -2
    run_op(MIN_NEG, 32'hFFFF_FFFF);       // overflow case
    run_op(32'd0, 32'd5);
    run_op(MIN_NEG, 32'd1);
    run_op(32'h7FFF_FFFF, MIN_NEG);

    // Start while busy is ignored, and operand changes after sampling have no effect.
    issue(32'd100, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    dividend  = 32'd9;
    divisor   = 32'd3;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    wait_result(lat, busy_ok);
    check("busy_start_latency", W'(lat), W'(28));
    last_hi = 32'd2;
    last_lo = 32'd14;
    repeat (40) @(negedge clk);
    check("no_extra_result", W'(sb.size()), W'(0));

    // Reset mid-operation discards the partial result.
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_hi", hi_out, '0);
    check("midrst_lo", lo_out, '0);
    check("midrst_flags", W'({div_busy, div_done, div_zero}), W'(0));
    reset   = 1'b0;
    last_hi = '0;
    last_lo = '0;
    run_op(32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: rb = -W'($urandom_range(1, 15));
        3: ra = MIN_NEG;
        default: ;
      endcase
      run_op(ra, rb);
    end

    check("sb_drained", W'(sb.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
